// File: rtl/seg7_scan_monitor_pkg.sv
// Shared 7-segment constants, FSM encoding and anode helpers for the scan monitor.
// The display encoder uses the same pattern table.
package seg7_scan_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low patterns, bit order g..a, indexed by hex value
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic       known;
        logic       blank;
        logic [3:0] value;
    } seg_dec_t;

    function automatic logic one_low(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    function automatic logic many_low(input logic [3:0] an);
        return $countones(~an) > 1;
    endfunction

    function automatic logic [1:0] anode_index(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_monitor_if.sv
// Display bus seen by the scan monitor: the driven an/seg lines plus the
// reconstructed digit state.
interface seg7_scan_monitor_if;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_blank;
    logic        frame_done;
    logic        multi_an;

    modport master (
        output an, seg,
        input  digits, digit_valid, digit_blank, frame_done, multi_an
    );

    modport slave (
        input  an, seg,
        output digits, digit_valid, digit_blank, frame_done, multi_an
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern.
// known=1 for hex 0-F, blank=1 for all segments off; anything else is unrecognised.
module seg7_pattern_decode
    import seg7_scan_monitor_pkg::*;
(
    input  logic [6:0] seg,
    output seg_dec_t   dec
);

    always_comb begin
        dec = '0;
        if (seg == SEG_BLANK) begin
            dec.blank = 1'b1;
        end else if (seg != SEG_DASH) begin
            for (int i = 0; i < 16; i++) begin
                if (seg == SEG_HEX[i]) begin
                    dec.known = 1'b1;
                    dec.value = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/seg7_scan_monitor.sv
// Reconstructs the four digits shown on a multiplexed active-low 7-segment display
// by waiting for {an,seg} to settle and decoding each settled pattern.
module seg7_scan_monitor
    import seg7_scan_monitor_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18
) (
    input logic                clk,
    input logic                reset,
    seg7_scan_monitor_if.slave bus
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    // The cycle that detects a change already holds the new value, so the count
    // finishes one short; this keeps capture STABLE_CYCLES edges after registration.
    localparam logic [SC_W-1:0]  CAP_AT  = SC_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       r_an, p_an;
    logic [6:0]       r_seg, p_seg;
    state_t           state;
    logic [SC_W-1:0]  stab_cnt;
    logic [1:0]       last_idx;
    logic [CNT_W-1:0] to_cnt [4];
    logic [3:0]       digit_val [4];
    logic [3:0]       valid_q, blank_q;
    logic             frame_q, multi_q;

    logic             changed, capture;
    logic [1:0]       cap_idx;
    seg_dec_t         dec;

    seg7_pattern_decode u_decode (
        .seg (r_seg),
        .dec (dec)
    );

    always_comb begin
        changed = {r_an, r_seg} != {p_an, p_seg};
        capture = (state == ST_SETTLE) && !changed && (stab_cnt == CAP_AT);
        cap_idx = anode_index(r_an);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an     <= 4'hF;
            r_seg    <= SEG_BLANK;
            p_an     <= 4'hF;
            p_seg    <= SEG_BLANK;
            state    <= ST_IDLE;
            stab_cnt <= '0;
            last_idx <= 2'd3;
            valid_q  <= '0;
            blank_q  <= '0;
            frame_q  <= 1'b0;
            multi_q  <= 1'b0;
            for (int d = 0; d < 4; d++) begin
                to_cnt[d]    <= '0;
                digit_val[d] <= '0;
            end
        end else begin
            r_an    <= bus.an;
            r_seg   <= bus.seg;
            p_an    <= r_an;
            p_seg   <= r_seg;
            multi_q <= many_low(r_an) && !many_low(p_an);

            if (changed) begin
                state    <= one_low(r_an) ? ST_SETTLE : ST_IDLE;
                stab_cnt <= '0;
            end else if (state == ST_SETTLE) begin
                if (capture) state <= ST_HOLD;
                else         stab_cnt <= stab_cnt + SC_W'(1);
            end

            if (capture) begin
                frame_q  <= (cap_idx <= last_idx);
                last_idx <= cap_idx;
            end else begin
                frame_q  <= 1'b0;
            end

            // A capture of a digit overrides its timeout in the same cycle
            for (int d = 0; d < 4; d++) begin
                if (capture && cap_idx == 2'(d)) begin
                    to_cnt[d] <= '0;
                    if (dec.known) begin
                        digit_val[d] <= dec.value;
                        valid_q[d]   <= 1'b1;
                        blank_q[d]   <= 1'b0;
                    end else if (dec.blank) begin
                        valid_q[d]   <= 1'b1;
                        blank_q[d]   <= 1'b1;
                    end else begin
                        valid_q[d]   <= 1'b0;
                        blank_q[d]   <= 1'b0;
                    end
                end else if (to_cnt[d] == TO_LAST) begin
                    valid_q[d] <= 1'b0;
                    blank_q[d] <= 1'b0;
                end else begin
                    to_cnt[d] <= to_cnt[d] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.digits      = {digit_val[3], digit_val[2], digit_val[1], digit_val[0]};
    assign bus.digit_valid = valid_q;
    assign bus.digit_blank = blank_q;
    assign bus.frame_done  = frame_q;
    assign bus.multi_an    = multi_q;

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Scoreboard bench for seg7_scan_monitor: a sample-history reference model predicts
// the outputs after every clock edge and a separate monitor compares them.
module tb_seg7_scan_monitor;

    localparam int STABLE = 16;
    localparam int TMO    = 300;
    localparam int CW     = 18;

    localparam logic [6:0] TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  blank;
        logic        fd;
        logic        ma;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_monitor_if bus ();

    seg7_scan_monitor #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    total = 0;
    int    bad   = 0;
    string phase = "init";
    obs_t  exp_q [$];
    obs_t  mon_exp, mon_act;
    int    mon_edge = 0;

    // Reference model state: sample history and per-digit last-capture time
    int          m_edge = 0;
    logic [10:0] m_prev, m_prev2;
    int          m_run;
    logic [3:0]  m_val [4];
    bit          m_vld [4];
    bit          m_blk [4];
    int          m_last_cap [4];
    int          m_last_idx;

    function automatic int lows(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) n++;
        return n;
    endfunction

    function automatic int hex_of(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (TAB[i] == s) return i;
        return -1;
    endfunction

    // Output after edge m_edge depends on samples up to the previous edge;
    // the sample taken at this edge is folded into the history afterwards.
    task automatic model_edge(input bit rst_v, input logic [3:0] a, input logic [6:0] s);
        obs_t o;
        int   d;
        int   h;
        m_edge++;
        o = '0;
        if (rst_v) begin
            for (int k = 0; k < 4; k++) begin
                m_val[k] = 4'h0; m_vld[k] = 1'b0; m_blk[k] = 1'b0; m_last_cap[k] = m_edge;
            end
            m_last_idx = 3;
            m_prev     = {4'hF, 7'h7F};
            m_prev2    = {4'hF, 7'h7F};
            m_run      = 1;
        end else begin
            d = -1;
            if (m_run == STABLE && lows(m_prev[10:7]) == 1)
                for (int k = 0; k < 4; k++) if (!m_prev[7+k]) d = k;
            if (d >= 0) begin
                h = hex_of(m_prev[6:0]);
                if (h >= 0) begin
                    m_val[d] = 4'(h); m_vld[d] = 1'b1; m_blk[d] = 1'b0;
                end else if (m_prev[6:0] == 7'h7F) begin
                    m_vld[d] = 1'b1; m_blk[d] = 1'b1;
                end else begin
                    m_vld[d] = 1'b0; m_blk[d] = 1'b0;
                end
                m_last_cap[d] = m_edge;
                o.fd = (d <= m_last_idx);
                m_last_idx = d;
            end
            for (int k = 0; k < 4; k++)
                if (k != d && m_edge - m_last_cap[k] >= TMO) begin
                    m_vld[k] = 1'b0; m_blk[k] = 1'b0;
                end
            o.ma = (lows(m_prev[10:7]) > 1) && (lows(m_prev2[10:7]) <= 1);
            m_prev2 = m_prev;
            if ({a, s} == m_prev) m_run++;
            else m_run = 1;
            m_prev = {a, s};
        end
        for (int k = 0; k < 4; k++) begin
            o.digits[4*k +: 4] = m_val[k];
            o.valid[k]         = m_vld[k];
            o.blank[k]         = m_blk[k];
        end
        exp_q.push_back(o);
    endtask

    task automatic step(input bit r, input logic [3:0] a, input logic [6:0] s, input int n);
        repeat (n) begin
            @(negedge clk);
            reset  = r;
            bus.an = a;
            bus.seg = s;
            model_edge(r, a, s);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_edge++;
            mon_exp = exp_q.pop_front();
            mon_act = {bus.digits, bus.digit_valid, bus.digit_blank, bus.frame_done, bus.multi_an};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                if (bad <= 25)
                    $display("FAIL sb_%s edge %0d: got d=%h v=%b b=%b fd=%b ma=%b want d=%h v=%b b=%b fd=%b ma=%b",
                             phase, mon_edge, mon_act.digits, mon_act.valid, mon_act.blank,
                             mon_act.fd, mon_act.ma, mon_exp.digits, mon_exp.valid,
                             mon_exp.blank, mon_exp.fd, mon_exp.ma);
            end
        end
    end

    initial begin
        int          ecap;
        logic [3:0]  one;
        logic [3:0]  a;
        logic [6:0]  s;
        int          sel;
        bus.an  = 4'hF;
        bus.seg = 7'h7F;

        phase = "reset";
        step(1'b1, 4'hF, 7'h7F, 1);

        phase = "single";
        step(1'b0, 4'b1110, 7'h78, 20);
        chk("single_digit0", {12'h0, bus.digits[3:0]}, 16'h0007);
        chk("single_valid", {12'h0, bus.digit_valid}, 16'h0001);

        phase = "glitch";
        repeat (2) begin
            step(1'b0, 4'b1101, 7'h24, 8);
            step(1'b0, 4'b1101, 7'h30, 8);
        end
        chk("glitch_no_capture", {12'h0, bus.digit_valid}, 16'h0001);
        step(1'b0, 4'b1101, 7'h30, 20);
        chk("glitch_digit1", {12'h0, bus.digits[7:4]}, 16'h0003);

        phase = "scan";
        repeat (3) begin
            step(1'b0, 4'b1110, 7'h00, 40);
            step(1'b0, 4'b1101, 7'h24, 40);
            step(1'b0, 4'b1011, 7'h0E, 40);
            step(1'b0, 4'b0111, 7'h7F, 40);
        end
        chk("scan_digits", {4'h0, bus.digits[11:0]}, 16'h0F28);
        chk("scan_valid", {12'h0, bus.digit_valid}, 16'h000F);
        chk("scan_blank", {12'h0, bus.digit_blank}, 16'h0008);

        phase = "unknown";
        step(1'b0, 4'b1011, 7'h12, 20);
        step(1'b0, 4'b1011, 7'h3F, 20);
        chk("dash_invalid", {15'h0, bus.digit_valid[2]}, 16'h0000);
        chk("dash_keeps_value", {12'h0, bus.digits[11:8]}, 16'h0005);

        phase = "timeout";
        step(1'b0, 4'b1110, 7'h40, 20);
        step(1'b0, 4'hF, 7'h7F, TMO + 20);
        chk("timeout_drop", {12'h0, bus.digit_valid}, 16'h0000);
        step(1'b0, 4'b1110, 7'h40, 20);
        ecap = m_last_cap[0];
        while (m_edge + 1 < ecap + TMO - STABLE) step(1'b0, 4'hF, 7'h7F, 1);
        step(1'b0, 4'b1110, 7'h79, 20);
        chk("expiry_recapture_valid", {15'h0, bus.digit_valid[0]}, 16'h0001);
        chk("expiry_recapture_val", {12'h0, bus.digits[3:0]}, 16'h0001);

        phase = "multi";
        step(1'b0, 4'b1100, 7'h7F, 10);
        step(1'b0, 4'b1110, 7'h78, 8);
        step(1'b1, 4'b1110, 7'h78, 1);
        step(1'b0, 4'b1110, 7'h78, 1);
        chk("reset_digits", bus.digits, 16'h0000);
        chk("reset_flags", {8'h0, bus.digit_valid, bus.digit_blank}, 16'h0000);
        step(1'b0, 4'b1110, 7'h78, 20);

        phase = "random";
        one = 4'b0001;
        repeat (200) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = ~(one << (sel % 4));
            else if (sel == 7) a = 4'hF;
            else               a = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 9);
            if (sel < 6)       s = TAB[$urandom_range(0, 15)];
            else if (sel == 6) s = 7'h7F;
            else if (sel == 7) s = 7'h3F;
            else               s = 7'($urandom_range(0, 127));
            step(1'b0, a, s, $urandom_range(1, 30));
        end

        phase = "drain";
        repeat (3) begin
            if (exp_q.size() != 0) @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
